// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Mixes COLS_PER_CYCLE columns per clock in place, valid/ready on both sides.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } fsm_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] work_q, work_d, work_mix;
  logic [2:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         last;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] a);
    return xt(a) ^ a;
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] s0, s1, s2, s3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    if (inv) begin
      s0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
      s1 = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
      s2 = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
      s3 = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
    end else begin
      s0 = xt(a0) ^ m3(a1) ^ a2 ^ a3;
      s1 = a0 ^ xt(a1) ^ m3(a2) ^ a3;
      s2 = a0 ^ a1 ^ xt(a2) ^ m3(a3);
      s3 = m3(a0) ^ a1 ^ a2 ^ xt(a3);
    end
    return {s0, s1, s2, s3};
  endfunction

  // Column c lives at bits [(3-c)*32 +: 32]; for 2-bit c, 3-c == ~c.
  always_comb begin
    logic [1:0] idx;
    logic [6:0] lo;
    idx      = 2'd0;
    lo       = 7'd0;
    work_mix = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx = cnt_q[1:0] + 2'(g);
      lo  = {~idx, 5'd0};
      work_mix[lo +: 32] = mix_col(work_q[lo +: 32], mode_q);
    end
  end

  assign last = (cnt_q + STEP) == 3'd4;

  always_comb begin
    fsm_d  = fsm_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          work_d = state_in;
          mode_d = inverse;
          cnt_d  = 3'd0;
          fsm_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        work_d = work_mix;
        cnt_d  = cnt_q + STEP;
        if (last) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      work_q <= 128'd0;
      cnt_q  <= 3'd0;
      mode_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign state_out = work_q;

endmodule
